// File: rtl/mcu_subsys_mem_arbiter.sv
// mcu_subsys_mem_arbiter
//   Two-master valid/ready arbiter in front of the single-port MCU SRAM.
//   m0 = CPU bus, m1 = DMA/capture bus. Only one access is in flight at a time.
//   The SRAM answers one cycle after it sees s_valid. s_valid is still high in the
//   completion cycle, so the SRAM raises a second, stale ready one cycle later.
//   The DRAIN state exists to swallow that stale ready.
//   Optional feature: define MCU_SUBSYS_MEM_ARB_TIMEOUT_EN to abort BUSY after
//   TIMEOUT_CYCLES cycles with no s_ready. The aborted access returns 32'hDEAD_BEEF
//   and pulses arb_err.
module mcu_subsys_mem_arbiter #(
  parameter int FIXED_PRIO     = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        arb_err
);
  localparam int NM = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t               r_state;
  logic                 r_last_grant;   // index of the master granted last
  logic                 r_owner;        // index of the master owning the access
  logic                 r_s_valid;
  logic [31:0]          r_s_addr;
  logic [31:0]          r_s_wdata;
  logic [3:0]           r_s_wstrb;
  logic [NM-1:0]        r_grant;
  logic [NM-1:0]        r_m_ready;
  logic [NM-1:0][31:0]  r_m_rdata;

  logic [NM-1:0]        w_req;
  logic                 w_owner;
  logic [31:0]          w_addr;
  logic [31:0]          w_wdata;
  logic [3:0]           w_wstrb;

`ifdef MCU_SUBSYS_MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0]        r_busy_cnt;
  logic                 r_arb_err;
  logic                 w_timeout;
  assign w_timeout = (r_busy_cnt == TO_LAST);
`endif

  assign w_req = {m1_valid, m0_valid};

  // Choose the next owner. Round-robin alternates on a tie; fixed priority favours m0.
  always_comb begin
    w_owner = 1'b0;
    if (&w_req)        w_owner = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
    else if (w_req[1]) w_owner = 1'b1;
  end

  assign w_addr  = w_owner ? m1_addr  : m0_addr;
  assign w_wdata = w_owner ? m1_wdata : m0_wdata;
  assign w_wstrb = w_owner ? m1_wstrb : m0_wstrb;

  // Access sequencer: IDLE -> BUSY (wait for s_ready) -> DRAIN (drop the stale ready) -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_s_valid    <= 1'b0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_s_wstrb    <= '0;
      r_grant      <= '0;
      r_m_ready    <= '0;
      r_m_rdata    <= '0;
`ifdef MCU_SUBSYS_MEM_ARB_TIMEOUT_EN
      r_busy_cnt   <= '0;
      r_arb_err    <= 1'b0;
`endif
    end else begin
`ifdef MCU_SUBSYS_MEM_ARB_TIMEOUT_EN
      r_arb_err <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_owner      <= w_owner;
            r_last_grant <= w_owner;
            r_s_addr     <= w_addr;
            r_s_wdata    <= w_wdata;
            r_s_wstrb    <= w_wstrb;
            r_s_valid    <= 1'b1;
            r_grant      <= w_owner ? 2'b10 : 2'b01;
            r_state      <= ST_BUSY;
`ifdef MCU_SUBSYS_MEM_ARB_TIMEOUT_EN
            r_busy_cnt   <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (s_ready) begin
            r_s_valid          <= 1'b0;
            r_m_ready[r_owner] <= 1'b1;
            r_m_rdata[r_owner] <= s_rdata;
            r_state            <= ST_DRAIN;
          end
`ifdef MCU_SUBSYS_MEM_ARB_TIMEOUT_EN
          else if (w_timeout) begin
            r_s_valid          <= 1'b0;
            r_m_ready[r_owner] <= 1'b1;
            r_m_rdata[r_owner] <= 32'hDEAD_BEEF;
            r_arb_err          <= 1'b1;
            r_state            <= ST_DRAIN;
          end else begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
          end
`endif
        end
        ST_DRAIN: begin
          r_grant   <= '0;
          r_m_ready <= '0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_valid  = r_s_valid;
  assign s_addr   = r_s_addr;
  assign s_wdata  = r_s_wdata;
  assign s_wstrb  = r_s_wstrb;
  assign grant    = r_grant;
  assign m0_ready = r_m_ready[0];
  assign m1_ready = r_m_ready[1];
  assign m0_rdata = r_m_rdata[0];
  assign m1_rdata = r_m_rdata[1];
`ifdef MCU_SUBSYS_MEM_ARB_TIMEOUT_EN
  assign arb_err  = r_arb_err;
`else
  assign arb_err  = 1'b0;
`endif

endmodule
